conv_frame_sequencer: RTL and testbench

Frame-level sequencer for the streaming K×K convolver datapath. It accepts one IMAGE_SIZE×IMAGE_SIZE frame of pixels in raster order through a valid/ready handshake and drives the line-buffer shift enable. It tracks row and column position, flags every valid convolution window, and presents window-valid with output coordinates to downstream under backpressure. It sits between the pixel source and the convolver datapath and replaces free-running enable generation with start/done frame control.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_frame_sequencer_raster_counter.sv | 56 +++++
 rtl/conv_frame_sequencer.sv | 112 +++++++++++
 tb/tb_conv_frame_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding, default frame geometry and coordinate width helper
package conv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_IMAGE_SIZE  = 28;
  localparam int DEFAULT_KERNEL_SIZE = 5;

  // Never narrower than one bit, so a 1x1 or 2x2 frame still gets a counter.
  function automatic int coord_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv_frame_sequencer_raster_counter.sv
// rtl/conv_frame_sequencer_raster_counter.sv - raster row/col position with last-pixel and window-hit flags
module raster_counter
  import conv_pkg::*;
#(
  parameter int IMAGE_SIZE  = DEFAULT_IMAGE_SIZE,
  parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
  parameter int CW          = coord_width(IMAGE_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear_i,
  input  logic          en_i,
  output logic [CW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic          last_pixel_o,
  output logic          window_hit_o
);

  localparam logic [CW-1:0] LAST = CW'(IMAGE_SIZE - 1);
  localparam logic [CW-1:0] KM1  = CW'(KERNEL_SIZE - 1);

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == LAST) begin
        col_d = '0;
        row_d = (row_q == LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o        = row_q;
  assign col_o        = col_q;
  assign last_pixel_o = (row_q == LAST) && (col_q == LAST);
  assign window_hit_o = (row_q >= KM1) && (col_q >= KM1);

endmodule

// File: rtl/conv_frame_sequencer.sv
// rtl/conv_frame_sequencer.sv - frame sequencer: start/done control, pixel handshake, one-entry window output stage
module conv_frame_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int IMAGE_SIZE  = DEFAULT_IMAGE_SIZE,
  parameter int KERNEL_SIZE = DEFAULT_KERNEL_SIZE,
  localparam int CW         = coord_width(IMAGE_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic          shift_en,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          busy,
  output logic          frame_done
);

  if (DATA_WIDTH < 1 || KERNEL_SIZE < 1 || IMAGE_SIZE < KERNEL_SIZE) begin : g_param_check
    $error("conv_frame_sequencer: invalid DATA_WIDTH/IMAGE_SIZE/KERNEL_SIZE");
  end

  localparam logic [CW-1:0] KM1 = CW'(KERNEL_SIZE - 1);

  state_e        state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [CW-1:0] out_row_q, out_row_d;
  logic [CW-1:0] out_col_q, out_col_d;
  logic          cnt_clear;
  logic [CW-1:0] row, col;
  logic          last_pixel, window_hit;

  raster_counter #(
    .IMAGE_SIZE  (IMAGE_SIZE),
    .KERNEL_SIZE (KERNEL_SIZE),
    .CW          (CW)
  ) u_raster (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (cnt_clear),
    .en_i         (shift_en),
    .row_o        (row),
    .col_o        (col),
    .last_pixel_o (last_pixel),
    .window_hit_o (window_hit)
  );

  // A pixel may enter whenever the output slot is empty or being drained this cycle.
  assign pix_ready = (state_q == ST_STREAM) && (!out_valid_q || out_ready);
  assign shift_en  = pix_valid && pix_ready;

  always_comb begin
    state_d     = state_q;
    cnt_clear   = 1'b0;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_STREAM;
          cnt_clear = 1'b1;
        end
      end
      ST_STREAM: begin
        if (shift_en && last_pixel) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (out_valid_q && out_ready) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (shift_en && window_hit) begin
      out_valid_d = 1'b1;
      out_row_d   = row - KM1;
      out_col_d   = col - KM1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb/tb_conv_frame_sequencer.sv - bench for conv_frame_sequencer at 28x28/K5, 5x5/K5 and 28x28/K1
module tb_conv_frame_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start = 1'b0;
  logic pix_valid = 1'b0;
  logic out_ready = 1'b1;

  logic [2:0] pr, se, ov, bz, fd;
  logic [4:0] r0, c0, r2, c2;
  logic [2:0] r1, c1;

  conv_frame_sequencer #(.DATA_WIDTH(16), .IMAGE_SIZE(28), .KERNEL_SIZE(5)) u0 (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_ready(pr[0]),
    .shift_en(se[0]), .out_valid(ov[0]), .out_ready(out_ready), .out_row(r0), .out_col(c0),
    .busy(bz[0]), .frame_done(fd[0]));

  conv_frame_sequencer #(.DATA_WIDTH(16), .IMAGE_SIZE(5), .KERNEL_SIZE(5)) u1 (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_ready(pr[1]),
    .shift_en(se[1]), .out_valid(ov[1]), .out_ready(out_ready), .out_row(r1), .out_col(c1),
    .busy(bz[1]), .frame_done(fd[1]));

  conv_frame_sequencer #(.DATA_WIDTH(16), .IMAGE_SIZE(28), .KERNEL_SIZE(1)) u2 (
    .clk(clk), .reset(reset), .start(start), .pix_valid(pix_valid), .pix_ready(pr[2]),
    .shift_en(se[2]), .out_valid(ov[2]), .out_ready(out_ready), .out_row(r2), .out_col(c2),
    .busy(bz[2]), .frame_done(fd[2]));

  int ns [3] = '{28, 5, 28};
  int ks [3] = '{5, 5, 1};

  int cmp_cnt = 0;
  int err_cnt = 0;

  int m_row [3], m_col [3], acc [3], outs [3], done_cnt [3];
  bit pend_done [3], busy_chk [3], exp_ov [3], held [3];
  int held_r [3], held_c [3];
  int exp_q [3][$];

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s[%0d]: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Scoreboard: accepts push expected windows, output handshakes pop and compare.
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      int rr, cc, n, k, e;
      n  = ns[i];
      k  = ks[i];
      rr = (i == 0) ? int'(r0) : ((i == 1) ? int'(r1) : int'(r2));
      cc = (i == 0) ? int'(c0) : ((i == 1) ? int'(c1) : int'(c2));
      if (reset) begin
        m_row[i] = 0; m_col[i] = 0; acc[i] = 0; outs[i] = 0;
        pend_done[i] = 0; busy_chk[i] = 0; exp_ov[i] = 0; held[i] = 0;
        exp_q[i].delete();
      end else begin
        if (busy_chk[i]) begin
          chk("busy_after_done", i, int'(bz[i]), 0);
          busy_chk[i] = 0;
        end
        if (pend_done[i] || fd[i]) begin
          chk("frame_done", i, int'(fd[i]), int'(pend_done[i]));
          if (fd[i]) begin
            chk("frame_accepts", i, acc[i], n * n);
            chk("frame_outputs", i, outs[i], (n - k + 1) * (n - k + 1));
            done_cnt[i]++;
            acc[i] = 0;
            outs[i] = 0;
            busy_chk[i] = 1;
          end
        end
        pend_done[i] = 0;
        if (exp_ov[i]) chk("window_latency", i, int'(ov[i]), 1);
        if (held[i]) begin
          chk("hold_valid", i, int'(ov[i]), 1);
          chk("hold_row", i, rr, held_r[i]);
          chk("hold_col", i, cc, held_c[i]);
        end
        if (ov[i] && !out_ready) chk("pix_ready_stall", i, int'(pr[i]), 0);
        chk("shift_en", i, int'(se[i]), int'(pix_valid & pr[i]));
        if (ov[i] && out_ready) begin
          outs[i]++;
          if (exp_q[i].size() == 0) begin
            chk("unexpected_output", i, 1, 0);
          end else begin
            e = exp_q[i].pop_front();
            chk("out_row", i, rr, e / 256);
            chk("out_col", i, cc, e % 256);
          end
          if (outs[i] == (n - k + 1) * (n - k + 1)) pend_done[i] = 1;
        end
        exp_ov[i] = 0;
        if (se[i]) begin
          acc[i]++;
          if (m_row[i] >= k - 1 && m_col[i] >= k - 1) begin
            exp_q[i].push_back((m_row[i] - k + 1) * 256 + (m_col[i] - k + 1));
            exp_ov[i] = 1;
          end
          if (m_col[i] == n - 1) begin
            m_col[i] = 0;
            m_row[i] = (m_row[i] == n - 1) ? 0 : m_row[i] + 1;
          end else begin
            m_col[i]++;
          end
        end
        held[i]   = ov[i] && !out_ready;
        held_r[i] = rr;
        held_c[i] = cc;
      end
    end
  end

  task automatic cyc(input bit r, input bit s, input bit pv, input bit o);
    @(posedge clk);
    #1;
    reset = r; start = s; pix_valid = pv; out_ready = o;
  endtask

  task automatic wait_idle(input bit rnd, input int budget);
    int n;
    n = 0;
    do begin
      cyc(1'b0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
      @(negedge clk);
      #1;
    end while (bz != 3'b000 && n < budget);
    chk("idle_within_budget", 0, int'(bz == 3'b000), 1);
  endtask

  typedef struct {
    bit rst, st, pv, ordy;
    bit e_pr, e_bz, e_ov, e_se;
  } vec_t;
  vec_t vt [8];

  initial begin
    int n;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vt[0] = '{1, 0, 0, 1, 0, 0, 0, 0};
    vt[1] = '{1, 0, 1, 1, 0, 0, 0, 0};
    vt[2] = '{0, 0, 1, 1, 0, 0, 0, 0};
    vt[3] = '{0, 1, 1, 1, 0, 0, 0, 0};
    vt[4] = '{0, 0, 1, 1, 1, 1, 0, 1};
    vt[5] = '{0, 0, 0, 1, 1, 1, 0, 0};
    vt[6] = '{0, 0, 1, 0, 1, 1, 0, 1};
    vt[7] = '{0, 0, 1, 1, 1, 1, 0, 1};

    for (int v = 0; v < 8; v++) begin
      cyc(vt[v].rst, vt[v].st, vt[v].pv, vt[v].ordy);
      @(negedge clk);
      #1;
      chk("vec_pix_ready", v, int'(pr[0]), int'(vt[v].e_pr));
      chk("vec_busy", v, int'(bz[0]), int'(vt[v].e_bz));
      chk("vec_out_valid", v, int'(ov[0]), int'(vt[v].e_ov));
      chk("vec_shift_en", v, int'(se[0]), int'(vt[v].e_se));
      chk("vec_frame_done", v, int'(fd[0]), 0);
    end

    // Frame 1: continuous flow.
    wait_idle(1'b0, 5000);
    chk("frames_after_t1", 0, done_cnt[0], 1);

    // Frame 2: hold out_ready low across the first window.
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      n++;
    end while (!ov[0] && n < 300);
    chk("first_window_seen", 0, int'(ov[0]), 1);
    chk("accepts_at_first_window", 0, acc[0], 117);
    for (int j = 0; j < 10; j++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk("bp_pix_ready", j, int'(pr[0]), 0);
      chk("bp_out_valid", j, int'(ov[0]), 1);
      chk("bp_row", j, int'(r0), 0);
      chk("bp_col", j, int'(c0), 0);
    end
    wait_idle(1'b0, 5000);
    chk("frames_after_t2", 0, done_cnt[0], 2);

    // Frame 3: random source gaps and random backpressure.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    wait_idle(1'b1, 20000);
    chk("frames_after_t3", 0, done_cnt[0], 3);

    // Frame 4: start pulses while busy are ignored; then a second full frame.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    for (int j = 0; j < 300; j++) cyc(1'b0, (j % 50) == 7, 1'b1, 1'b1);
    wait_idle(1'b0, 5000);
    chk("frames_after_t4a", 0, done_cnt[0], 4);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    wait_idle(1'b0, 5000);
    chk("frames_after_t4b", 0, done_cnt[0], 5);

    // Frame 5: reset mid-frame at (10,7), then a clean frame.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    n = 0;
    do begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      #1;
      n++;
    end while (!(m_row[0] == 10 && m_col[0] == 7) && n < 1000);
    chk("reached_10_7", 0, int'(m_row[0] == 10 && m_col[0] == 7), 1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_out_valid", i, int'(ov[i]), 0);
      chk("post_reset_pix_ready", i, int'(pr[i]), 0);
      chk("post_reset_busy", i, int'(bz[i]), 0);
    end
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    wait_idle(1'b0, 5000);
    chk("frames_total_k5", 0, done_cnt[0], 6);
    chk("frames_total_k1", 2, done_cnt[2], 6);
    for (int i = 0; i < 3; i++) chk("queue_drained", i, exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
